// File: rtl/ram1rw_arbiter.sv
// ram1rw_arbiter
//   Shares one single-port, registered-input RAM (2-cycle read) between two
//   requesters with round-robin arbitration, routes each read response back
//   to its requester, and zero-fills the array after reset or on request.
//
// State table:
//   state    | meaning
//   ST_IDLE  | arbitrate requester traffic onto the RAM port
//   ST_CLEAR | write zeros to clr_addr = 0..DEPTH-1, one per cycle; readys low
//
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   req{0,1}_valid/_wr/_addr/_wr_data   request from each requester
//   req{0,1}_ready               request accepted this cycle (combinational)
//   clear_req                    start a zero-fill (ignored while busy)
//   busy                         high while in ST_CLEAR
//   rsp{0,1}_valid               rsp_data belongs to requester 0 / 1
//   rsp_data                     RAM read data
module ram1rw_arbiter #(
  parameter int WIDTH          = 64,
  parameter int LG_DEPTH       = 6,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req0_valid,
  input  logic                req0_wr,
  input  logic [LG_DEPTH-1:0] req0_addr,
  input  logic [WIDTH-1:0]    req0_wr_data,
  output logic                req0_ready,
  input  logic                req1_valid,
  input  logic                req1_wr,
  input  logic [LG_DEPTH-1:0] req1_addr,
  input  logic [WIDTH-1:0]    req1_wr_data,
  output logic                req1_ready,
  input  logic                clear_req,
  output logic                busy,
  output logic                rsp0_valid,
  output logic                rsp1_valid,
  output logic [WIDTH-1:0]    rsp_data
);

  localparam int DEPTH = 1 << LG_DEPTH;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t              state;
  logic [LG_DEPTH-1:0] clr_addr;
  logic                last;
  logic                trk_valid;
  logic                trk_id;

  logic                arb_en;
  logic                grant0;
  logic                grant1;

  logic [LG_DEPTH-1:0] ram_addr;
  logic                ram_wr_en;
  logic [WIDTH-1:0]    ram_wr_data;
  logic [WIDTH-1:0]    ram_rd_data;

  // Reset gates grants so readys stay low even when CLEAR_ON_RESET = 0.
  assign arb_en = (state == ST_IDLE) && !reset;
  // On a tie the requester that did not win last time is granted.
  assign grant0 = arb_en && req0_valid && (!req1_valid || last);
  assign grant1 = arb_en && req1_valid && (!req0_valid || !last);

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign busy       = (state == ST_CLEAR);
  assign rsp_data   = ram_rd_data;

  always_comb begin
    ram_addr    = '0;
    ram_wr_en   = 1'b0;
    ram_wr_data = '0;
    if (!reset) begin
      if (state == ST_CLEAR) begin
        ram_addr  = clr_addr;
        ram_wr_en = 1'b1;
      end else if (grant0) begin
        ram_addr    = req0_addr;
        ram_wr_en   = req0_wr;
        ram_wr_data = req0_wr_data;
      end else if (grant1) begin
        ram_addr    = req1_addr;
        ram_wr_en   = req1_wr;
        ram_wr_data = req1_wr_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      clr_addr   <= '0;
      last       <= 1'b1;
      trk_valid  <= 1'b0;
      trk_id     <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
    end else begin
      // Two-stage read tracker: stage 1 is {trk_valid, trk_id}, stage 2 is
      // the decoded response valids, lining up with the RAM's 2-cycle read.
      trk_valid  <= (grant0 && !req0_wr) || (grant1 && !req1_wr);
      trk_id     <= grant1;
      rsp0_valid <= trk_valid && !trk_id;
      rsp1_valid <= trk_valid && trk_id;

      if (grant0 || grant1) begin
        last <= grant1;
      end

      case (state)
        ST_IDLE: begin
          if (clear_req) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
          end
        end
        ST_CLEAR: begin
          if (clr_addr == {LG_DEPTH{1'b1}}) begin
            state    <= ST_IDLE;
            clr_addr <= '0;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Single-port RAM, reg_ram1rw behaviour: inputs are registered, the array
  // write and the read of the registered address happen in the following
  // cycle, and read data is registered once more. The array is not reset.
  logic [LG_DEPTH-1:0] ram_addr_q;
  logic                ram_wr_en_q;
  logic [WIDTH-1:0]    ram_wr_data_q;
  logic [WIDTH-1:0]    mem [DEPTH];

  always_ff @(posedge clk) begin
    ram_addr_q    <= ram_addr;
    ram_wr_en_q   <= ram_wr_en;
    ram_wr_data_q <= ram_wr_data;
  end

  always_ff @(posedge clk) begin
    if (ram_wr_en_q) begin
      mem[ram_addr_q] <= ram_wr_data_q;
    end
    ram_rd_data <= mem[ram_addr_q];
  end

endmodule

// File: tb/tb_ram1rw_arbiter.sv
// Testbench for ram1rw_arbiter (WIDTH=64, LG_DEPTH=4, CLEAR_ON_RESET=1).
// A behavioural model (memory array, round-robin winner, pending-response
// queue keyed by due cycle, clear countdown) predicts every cycle's outputs.
module tb_ram1rw_arbiter;
  localparam int W  = 64;
  localparam int LG = 4;
  localparam int D  = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0_valid = 0, req0_wr = 0, req1_valid = 0, req1_wr = 0;
  logic [LG-1:0] req0_addr = '0, req1_addr = '0;
  logic [W-1:0]  req0_wr_data = '0, req1_wr_data = '0;
  logic          req0_ready, req1_ready;
  logic          clear_req = 1'b0;
  logic          busy, rsp0_valid, rsp1_valid;
  logic [W-1:0]  rsp_data;

  ram1rw_arbiter #(.WIDTH(W), .LG_DEPTH(LG), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_wr(req0_wr), .req0_addr(req0_addr),
    .req0_wr_data(req0_wr_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_wr(req1_wr), .req1_addr(req1_addr),
    .req1_wr_data(req1_wr_data), .req1_ready(req1_ready),
    .clear_req(clear_req), .busy(busy),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    bit         id;
    logic [W-1:0] data;
  } rsp_t;

  int           n_cmp = 0;
  int           n_fail = 0;
  int           cyc = 0;
  logic [W-1:0] mdl_mem [D];
  bit           mdl_last = 1'b1;
  bit           mdl_busy = 1'b1;
  int           clr_left = D;
  rsp_t         exp_q[$];

  logic          obs_r0, obs_r1, obs_busy, obs_v0, obs_v1;
  logic [W-1:0]  obs_data;
  logic [LG-1:0] obs_clr;
  logic          exp_r0, exp_r1, exp_busy, exp_v0, exp_v1;
  logic [W-1:0]  exp_data;
  logic [LG-1:0] exp_clr;

  task automatic drive(input bit v0, input bit w0, input logic [LG-1:0] a0,
                       input logic [W-1:0] d0, input bit v1, input bit w1,
                       input logic [LG-1:0] a1, input logic [W-1:0] d1,
                       input bit clr);
    req0_valid = v0; req0_wr = w0; req0_addr = a0; req0_wr_data = d0;
    req1_valid = v1; req1_wr = w1; req1_addr = a1; req1_wr_data = d1;
    clear_req  = clr;
  endtask

  task automatic drive_idle();
    drive(0, 0, '0, '0, 0, 0, '0, '0, 0);
  endtask

  task automatic drive_random(input bit allow_clear);
    drive($urandom_range(0, 1), $urandom_range(0, 1), 4'($urandom), {$urandom, $urandom},
          $urandom_range(0, 1), $urandom_range(0, 1), 4'($urandom), {$urandom, $urandom},
          allow_clear && ($urandom_range(0, 49) == 0));
  endtask

  // Samples the DUT mid-cycle, computes this cycle's expected outputs from
  // the model, then advances the model and the clock.
  task automatic run_cycle();
    rsp_t r;
    @(negedge clk);
    obs_r0 = req0_ready; obs_r1 = req1_ready; obs_busy = busy;
    obs_v0 = rsp0_valid; obs_v1 = rsp1_valid; obs_data = rsp_data;
    obs_clr = dut.clr_addr;
    exp_v0 = 0; exp_v1 = 0; exp_data = '0; exp_r0 = 0; exp_r1 = 0;
    if (reset) begin
      exp_busy = 1; exp_clr = '0;
      exp_q.delete();
      mdl_busy = 1; clr_left = D; mdl_last = 1;
      for (int k = 0; k < D; k++) mdl_mem[k] = '0;
    end else begin
      exp_busy = mdl_busy;
      exp_clr  = LG'(D - clr_left);
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        r = exp_q.pop_front();
        exp_v0 = !r.id; exp_v1 = r.id; exp_data = r.data;
      end
      if (!mdl_busy) begin
        if (req0_valid && req1_valid) begin
          exp_r0 = mdl_last; exp_r1 = !mdl_last;
        end else begin
          exp_r0 = req0_valid; exp_r1 = req1_valid;
        end
      end
      if (exp_r0 || exp_r1) begin
        r.id   = exp_r1;
        r.due  = cyc + 2;
        if (exp_r0) begin
          if (req0_wr) mdl_mem[req0_addr] = req0_wr_data;
          else begin r.data = mdl_mem[req0_addr]; exp_q.push_back(r); end
        end else begin
          if (req1_wr) mdl_mem[req1_addr] = req1_wr_data;
          else begin r.data = mdl_mem[req1_addr]; exp_q.push_back(r); end
        end
        mdl_last = exp_r1;
      end
      if (mdl_busy) begin
        clr_left--;
        if (clr_left == 0) mdl_busy = 0;
      end else if (clear_req) begin
        mdl_busy = 1; clr_left = D;
        for (int k = 0; k < D; k++) mdl_mem[k] = '0;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 24; i++) begin
      reset = (i < 3);
      if (i == 1) drive(1, 0, 4'd1, '0, 1, 0, 4'd2, '0, 0);
      else if (i == 20) drive(1, 0, 4'd9, '0, 0, 0, '0, '0, 0);
      else drive_idle();
      run_cycle();
      n_cmp++;
      if ({obs_r0, obs_r1, obs_busy, obs_v0, obs_v1} !== {exp_r0, exp_r1, exp_busy, exp_v0, exp_v1}) begin
        n_fail++;
        $display("FAIL reset_ctl i=%0d rdy0,rdy1,busy,rsp0,rsp1 got %b expected %b", i,
                 {obs_r0, obs_r1, obs_busy, obs_v0, obs_v1}, {exp_r0, exp_r1, exp_busy, exp_v0, exp_v1});
      end
      if (exp_v0 || exp_v1) begin
        n_cmp++;
        if (obs_data !== exp_data) begin
          n_fail++; $display("FAIL reset_data i=%0d got %h expected %h", i, obs_data, exp_data);
        end
      end
      if (exp_busy) begin
        n_cmp++;
        if (obs_clr !== exp_clr) begin
          n_fail++; $display("FAIL reset_clr_addr i=%0d got %0d expected %0d", i, obs_clr, exp_clr);
        end
      end
      if (i == 18 || i == 19) begin
        n_cmp++;
        if (obs_busy !== (i == 18)) begin
          n_fail++; $display("FAIL reset_busy_edge i=%0d got %b expected %b", i, obs_busy, (i == 18));
        end
      end
      if (i == 22) begin
        n_cmp++;
        if (!(obs_v0 === 1'b1 && obs_data === 64'd0)) begin
          n_fail++; $display("FAIL reset_read9 got v0=%b data=%h expected v0=1 data=0", obs_v0, obs_data);
        end
      end
    end
  endtask

  task automatic test_write_read();
    for (int i = 0; i < 5; i++) begin
      if (i == 0) drive(1, 1, 4'd3, 64'hAAAA, 0, 0, '0, '0, 0);
      else if (i == 1) drive(0, 0, '0, '0, 1, 0, 4'd3, '0, 0);
      else drive_idle();
      run_cycle();
      n_cmp++;
      if ({obs_r0, obs_r1, obs_busy, obs_v0, obs_v1} !== {exp_r0, exp_r1, exp_busy, exp_v0, exp_v1}) begin
        n_fail++;
        $display("FAIL wr_rd_ctl i=%0d got %b expected %b", i,
                 {obs_r0, obs_r1, obs_busy, obs_v0, obs_v1}, {exp_r0, exp_r1, exp_busy, exp_v0, exp_v1});
      end
      if (exp_v0 || exp_v1) begin
        n_cmp++;
        if (obs_data !== exp_data) begin
          n_fail++; $display("FAIL wr_rd_data i=%0d got %h expected %h", i, obs_data, exp_data);
        end
      end
      if (i == 3) begin
        n_cmp++;
        if (!(obs_v1 === 1'b1 && obs_data === 64'hAAAA)) begin
          n_fail++; $display("FAIL wr_rd_aaaa got v1=%b data=%h expected v1=1 data=aaaa", obs_v1, obs_data);
        end
      end
    end
  endtask

  task automatic test_alternate();
    for (int i = 0; i < 10; i++) begin
      if (i == 0) drive(0, 0, '0, '0, 1, 1, 4'd1, {$urandom, $urandom}, 0);
      else if (i == 1) drive(0, 0, '0, '0, 1, 1, 4'd2, {$urandom, $urandom}, 0);
      else if (i < 6) drive(1, 0, 4'd1, '0, 1, 0, 4'd2, '0, 0);
      else drive_idle();
      run_cycle();
      n_cmp++;
      if ({obs_r0, obs_r1, obs_busy, obs_v0, obs_v1} !== {exp_r0, exp_r1, exp_busy, exp_v0, exp_v1}) begin
        n_fail++;
        $display("FAIL alt_ctl i=%0d got %b expected %b", i,
                 {obs_r0, obs_r1, obs_busy, obs_v0, obs_v1}, {exp_r0, exp_r1, exp_busy, exp_v0, exp_v1});
      end
      if (exp_v0 || exp_v1) begin
        n_cmp++;
        if (obs_data !== exp_data) begin
          n_fail++; $display("FAIL alt_data i=%0d got %h expected %h", i, obs_data, exp_data);
        end
      end
      if (i >= 2 && i < 6) begin
        n_cmp++;
        if ({obs_r0, obs_r1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
          n_fail++; $display("FAIL alt_grant i=%0d got %b", i, {obs_r0, obs_r1});
        end
      end
    end
  endtask

  task automatic test_clear_inflight();
    for (int i = 0; i < 24; i++) begin
      if (i == 0) drive(1, 1, 4'd5, 64'h55, 0, 0, '0, '0, 0);
      else if (i == 1) drive(1, 0, 4'd5, '0, 0, 0, '0, '0, 0);
      else if (i == 2) drive(0, 0, '0, '0, 0, 0, '0, '0, 1);
      else if (i >= 4 && i <= 17) drive_random(0);
      else if (i == 20) drive(0, 0, '0, '0, 1, 0, 4'd5, '0, 0);
      else drive_idle();
      run_cycle();
      n_cmp++;
      if ({obs_r0, obs_r1, obs_busy, obs_v0, obs_v1} !== {exp_r0, exp_r1, exp_busy, exp_v0, exp_v1}) begin
        n_fail++;
        $display("FAIL clr_inflight_ctl i=%0d got %b expected %b", i,
                 {obs_r0, obs_r1, obs_busy, obs_v0, obs_v1}, {exp_r0, exp_r1, exp_busy, exp_v0, exp_v1});
      end
      if (exp_v0 || exp_v1) begin
        n_cmp++;
        if (obs_data !== exp_data) begin
          n_fail++; $display("FAIL clr_inflight_data i=%0d got %h expected %h", i, obs_data, exp_data);
        end
      end
      if (exp_busy) begin
        n_cmp++;
        if (obs_clr !== exp_clr) begin
          n_fail++; $display("FAIL clr_inflight_addr i=%0d got %0d expected %0d", i, obs_clr, exp_clr);
        end
      end
      if (i == 3) begin
        n_cmp++;
        if (!(obs_v0 === 1'b1 && obs_data === 64'h55)) begin
          n_fail++; $display("FAIL clr_inflight_old got v0=%b data=%h expected v0=1 data=55", obs_v0, obs_data);
        end
      end
      if (i == 22) begin
        n_cmp++;
        if (!(obs_v1 === 1'b1 && obs_data === 64'd0)) begin
          n_fail++; $display("FAIL clr_inflight_zero got v1=%b data=%h expected v1=1 data=0", obs_v1, obs_data);
        end
      end
    end
  endtask

  task automatic test_clear_retrigger();
    for (int i = 0; i < 19; i++) begin
      if (i == 0) drive(0, 0, '0, '0, 0, 0, '0, '0, 1);
      else if (i >= 1 && i <= 16) begin
        drive_random(0);
        clear_req = (i == 5 || i == 10);
      end else drive_idle();
      run_cycle();
      n_cmp++;
      if ({obs_r0, obs_r1, obs_busy, obs_v0, obs_v1} !== {exp_r0, exp_r1, exp_busy, exp_v0, exp_v1}) begin
        n_fail++;
        $display("FAIL retrig_ctl i=%0d got %b expected %b", i,
                 {obs_r0, obs_r1, obs_busy, obs_v0, obs_v1}, {exp_r0, exp_r1, exp_busy, exp_v0, exp_v1});
      end
      if (exp_busy) begin
        n_cmp++;
        if (obs_clr !== exp_clr) begin
          n_fail++; $display("FAIL retrig_addr i=%0d got %0d expected %0d", i, obs_clr, exp_clr);
        end
      end
      if (i == 16 || i == 17) begin
        n_cmp++;
        if (obs_busy !== (i == 16)) begin
          n_fail++; $display("FAIL retrig_busy_edge i=%0d got %b expected %b", i, obs_busy, (i == 16));
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive_random(1);
      run_cycle();
      n_cmp++;
      if ({obs_r0, obs_r1, obs_busy, obs_v0, obs_v1} !== {exp_r0, exp_r1, exp_busy, exp_v0, exp_v1}) begin
        n_fail++;
        $display("FAIL rand_ctl i=%0d got %b expected %b", i,
                 {obs_r0, obs_r1, obs_busy, obs_v0, obs_v1}, {exp_r0, exp_r1, exp_busy, exp_v0, exp_v1});
      end
      if (exp_v0 || exp_v1) begin
        n_cmp++;
        if (obs_data !== exp_data) begin
          n_fail++; $display("FAIL rand_data i=%0d got %h expected %h", i, obs_data, exp_data);
        end
      end
      if (exp_busy) begin
        n_cmp++;
        if (obs_clr !== exp_clr) begin
          n_fail++; $display("FAIL rand_clr_addr i=%0d got %0d expected %0d", i, obs_clr, exp_clr);
        end
      end
    end
  endtask

  task automatic test_reset_inflight();
    for (int i = 0; i < 22; i++) begin
      reset = (i >= 1 && i <= 3);
      if (i == 0) drive(1, 0, 4'($urandom), '0, 0, 0, '0, '0, 0);
      else if (i <= 3) drive(1, 0, 4'd1, '0, 1, 1, 4'd2, 64'h1, 0);
      else drive_idle();
      run_cycle();
      n_cmp++;
      if ({obs_r0, obs_r1, obs_busy, obs_v0, obs_v1} !== {exp_r0, exp_r1, exp_busy, exp_v0, exp_v1}) begin
        n_fail++;
        $display("FAIL rst_inflight_ctl i=%0d got %b expected %b", i,
                 {obs_r0, obs_r1, obs_busy, obs_v0, obs_v1}, {exp_r0, exp_r1, exp_busy, exp_v0, exp_v1});
      end
      if (exp_busy) begin
        n_cmp++;
        if (obs_clr !== exp_clr) begin
          n_fail++; $display("FAIL rst_inflight_addr i=%0d got %0d expected %0d", i, obs_clr, exp_clr);
        end
      end
      if (i == 2) begin
        n_cmp++;
        if ({obs_v0, obs_v1} !== 2'b00) begin
          n_fail++; $display("FAIL rst_inflight_drop got rsp0,rsp1=%b expected 00", {obs_v0, obs_v1});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_alternate();
    test_clear_inflight();
    test_clear_retrigger();
    test_random();
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
